// File: rtl/fifo_pkg.sv
// fifo_pkg: shared data width and occupancy encodings for the FIFO stream reader
package fifo_pkg;
  localparam int DATA_WIDTH = 16;
  typedef logic [1:0] occ_t;
  localparam occ_t OCC_EMPTY = 2'd0;
  localparam occ_t OCC_ONE = 2'd1;
  localparam occ_t OCC_TWO = 2'd2;
endpackage

// File: rtl/fifo_skid_buf.sv
// fifo_skid_buf: 2-entry head/tail register buffer; push writes the tail slot, pop removes the head
// Ports: clk, reset (sync, active-low), push/din (write a word), pop (drop head),
//        head (oldest word), cnt (occupancy: OCC_EMPTY/OCC_ONE/OCC_TWO)
module fifo_skid_buf
  import fifo_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] head,
  output occ_t                  cnt
);
  logic [DATA_WIDTH-1:0] tail;
  logic load_head, load_tail;
  // A pushed word becomes head when the buffer is (or is about to be) empty, otherwise it waits in tail
  always_comb begin
    load_head = push && (cnt == OCC_EMPTY || (cnt == OCC_ONE && pop));
    load_tail = push && (cnt == OCC_TWO || (cnt == OCC_ONE && !pop));
  end
  always_ff @(posedge clk)
    if (!reset) begin
      head <= '0;
      tail <= '0;
      cnt <= OCC_EMPTY;
    end else begin
      head <= (pop && cnt == OCC_TWO) ? tail : load_head ? din : head;
      tail <= load_tail ? din : tail;
      cnt <= occ_t'(cnt + occ_t'(push) - occ_t'(pop));
    end
endmodule

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a 1-cycle-latency FIFO read port into a valid/ready stream at 1 word/cycle
// Ports: clk, reset (sync, active-low), fifo_empty/fifo_data/fifo_rd_en (FIFO read side),
//        out_valid/out_ready/out_data (downstream stream),
//        word_count (only with FIFO_STREAM_READER_COUNT_EN: transfers since reset, wraps at 16 bits)
module fifo_stream_reader
  import fifo_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_en,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data
`ifdef FIFO_STREAM_READER_COUNT_EN
  ,
  output logic [15:0]           word_count
`endif
);
  occ_t cnt;
  logic pend, pop;
  logic [2:0] level;
  // Read only if the word still in flight plus what stays buffered leaves room for one more
  always_comb begin
    out_valid = cnt != OCC_EMPTY;
    pop = out_valid && out_ready;
    level = 3'(cnt) + 3'(pend) - 3'(pop);
    fifo_rd_en = reset && !fifo_empty && level <= 3'd1;
  end
  always_ff @(posedge clk)
    if (!reset) pend <= 1'b0;
    else pend <= fifo_rd_en;
`ifdef FIFO_STREAM_READER_COUNT_EN
  always_ff @(posedge clk)
    if (!reset) word_count <= '0;
    else if (pop) word_count <= word_count + 16'd1;
`endif
  fifo_skid_buf u_buf (
    .clk  (clk),
    .reset(reset),
    .push (pend),
    .pop  (pop),
    .din  (fifo_data),
    .head (out_data),
    .cnt  (cnt)
  );
endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: queue-modelled FIFO feeding the reader, scoreboard monitor on the output stream
module tb_fifo_stream_reader;
  logic clk = 0, reset = 0, fifo_empty = 1, out_ready = 0;
  logic [15:0] fifo_data = 0;
  logic fifo_rd_en, out_valid;
  logic [15:0] out_data;
`ifdef FIFO_STREAM_READER_COUNT_EN
  logic [15:0] word_count;
`endif
  logic [15:0] fq[$];
  logic [15:0] exp_q[$];
  int total = 0, bad = 0, rd_cnt = 0, xfer = 0, k, base;
  bit stalled = 0;
  logic [15:0] prev_data;

  fifo_stream_reader dut (
    .clk       (clk),
    .reset     (reset),
    .fifo_empty(fifo_empty),
    .fifo_data (fifo_data),
    .fifo_rd_en(fifo_rd_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef FIFO_STREAM_READER_COUNT_EN
    ,
    .word_count(word_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic load(logic [15:0] w);
    fq.push_back(w);
    exp_q.push_back(w);
  endtask

  always @(posedge clk) begin
    if (fifo_rd_en && fq.size() != 0) fifo_data <= fq.pop_front();
    #1 fifo_empty = fq.size() == 0;
  end

  always @(negedge clk) begin
    if (!reset) begin
      stalled = 0;
      xfer = 0;
    end else begin
      if (fifo_rd_en) begin
        rd_cnt++;
        chk("rd_while_empty", 32'(fifo_empty), 0);
      end
      if (stalled) chk("stall_hold", {out_valid, out_data}, {1'b1, prev_data});
      if (out_valid && out_ready) begin
        xfer++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_word: got %0h want none", out_data);
        end else chk("order", out_data, exp_q.pop_front());
      end
      stalled = out_valid && !out_ready;
      prev_data = out_data;
    end
  end

  initial begin
    out_ready = 1;
    for (int i = 0; i < 8; i++) load(16'(i));
    repeat (2) begin
      @(negedge clk);
      chk("rst_rd_en", 32'(fifo_rd_en), 0);
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_data", out_data, 0);
    end
    @(posedge clk); #2 reset = 1;
    k = 0;
    do begin @(negedge clk); k++; end while (!fifo_rd_en && k < 10);
    chk("rd_start", 32'(fifo_rd_en), 1);
    k = 0;
    do begin @(negedge clk); k++; end while (!out_valid && k < 10);
    chk("latency", k, 2);
    for (int i = 0; i < 8; i++) begin
      if (i != 0) @(negedge clk);
      chk("stream", {out_valid, out_data}, {1'b1, 16'(i)});
    end
    @(negedge clk);
    chk("valid_fall", 32'(out_valid), 0);

    @(posedge clk); #2 out_ready = 0;
    base = rd_cnt;
    for (int i = 0; i < 8; i++) load(16'(16'h100 + i));
    repeat (12) @(negedge clk);
    chk("bp_reads", rd_cnt - base, 2);
    chk("bp_head", {out_valid, out_data}, {1'b1, 16'h100});
    chk("bp_fifo_left", fq.size(), 6);
    @(posedge clk); #2 out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("bp_stream", {out_valid, out_data}, {1'b1, 16'(16'h100 + i)});
    end
    @(negedge clk);
    chk("bp_fall", 32'(out_valid), 0);

    base = rd_cnt;
    repeat (20) @(negedge clk);
    chk("empty_reads", rd_cnt - base, 0);
    chk("empty_valid", 32'(out_valid), 0);

    @(posedge clk); #2 out_ready = 0;
    base = rd_cnt;
    load(16'h200); load(16'h201); load(16'h202);
    k = 0;
    do begin @(negedge clk); k++; end while (!out_valid && k < 10);
    chk("mid_reads", rd_cnt - base, 2);
    #1 reset = 0;
    @(negedge clk);
    chk("mid_valid", 32'(out_valid), 0);
    fq.delete();
    exp_q.delete();
    @(posedge clk); #2 reset = 1; out_ready = 1;
    load(16'h00AA);
    k = 0;
    do begin @(negedge clk); k++; end while (!out_valid && k < 10);
    chk("mid_first", {out_valid, out_data}, {1'b1, 16'h00AA});

    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #2;
      out_ready = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) load(16'($urandom));
    end
    @(posedge clk); #2 out_ready = 1;
    k = 0;
    while ((exp_q.size() != 0 || out_valid) && k < 300) begin @(negedge clk); k++; end
    chk("drain", exp_q.size(), 0);
    chk("drain_valid", 32'(out_valid), 0);

`ifdef FIFO_STREAM_READER_COUNT_EN
    chk("count_now", word_count, 16'(xfer));
    @(posedge clk); #2 reset = 0;
    @(posedge clk); #2 reset = 1;
    @(negedge clk);
    chk("count_reset", word_count, 0);
    for (int i = 0; i < 32'h10002; i++) load(16'(i));
    k = 0;
    while ((exp_q.size() != 0 || out_valid) && k < 70000) begin @(negedge clk); k++; end
    @(negedge clk);
    chk("count_drain", exp_q.size(), 0);
    chk("count_wrap", word_count, 16'h0002);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
